// File: rtl/soc_timer_pkg.sv
// Register map and control/status bit layout shared by the multi-channel
// timer top level and its channel sub-module.
package soc_timer_pkg;

  localparam logic [2:0] REG_STATUS    = 3'd0;
  localparam logic [2:0] REG_CONTROL   = 3'd1;
  localparam logic [2:0] REG_PERIOD_LO = 3'd2;
  localparam logic [2:0] REG_PERIOD_HI = 3'd3;
  localparam logic [2:0] REG_SNAP_LO   = 3'd4;
  localparam logic [2:0] REG_SNAP_HI   = 3'd5;
  localparam logic [2:0] REG_PRESCALE  = 3'd6;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  function automatic logic [31:0] status_word(input logic run, input logic to);
    logic [31:0] w;
    w = '0;
    w[STAT_RUN] = run;
    w[STAT_TO]  = to;
    return w;
  endfunction

  // START/STOP are pulses, so only the persistent bits read back.
  function automatic logic [31:0] control_word(input logic cont, input logic ito);
    logic [31:0] w;
    w = '0;
    w[CTRL_CONT] = cont;
    w[CTRL_ITO]  = ito;
    return w;
  endfunction

endpackage

// File: rtl/soc_timer_channel.sv
// One timer channel: prescaled down-counter with reload, one-shot/continuous
// mode, snapshot capture and a maskable timeout interrupt.
module soc_timer_channel
  import soc_timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH  = 32,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [63:0] PERIOD_RESET   = 64'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [COUNTER_WIDTH-1:0] PERIOD_INIT = PERIOD_RESET[COUNTER_WIDTH-1:0];

  logic [COUNTER_WIDTH-1:0]  count_reg, count_next;
  logic [COUNTER_WIDTH-1:0]  period_reg, period_next;
  logic [COUNTER_WIDTH-1:0]  snap_reg, snap_next;
  logic [PRESCALE_WIDTH-1:0] presc_cnt_reg, presc_cnt_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic run_reg, run_next;
  logic to_reg, to_next;
  logic ito_reg, ito_next;
  logic cont_reg, cont_next;
  logic force_reload_reg, force_reload_next;

  logic [63:0] period_wide, snap_wide;
  logic wr_status, wr_control, wr_period_lo, wr_period_hi, wr_snap, wr_prescale;
  logic start, stop, tick, timeout;

  always_comb begin
    period_wide  = 64'(period_reg);
    snap_wide    = 64'(snap_reg);
    wr_status    = wr_en && (wr_idx == REG_STATUS);
    wr_control   = wr_en && (wr_idx == REG_CONTROL);
    wr_period_lo = wr_en && (wr_idx == REG_PERIOD_LO);
    wr_period_hi = wr_en && (wr_idx == REG_PERIOD_HI);
    wr_snap      = wr_en && ((wr_idx == REG_SNAP_LO) || (wr_idx == REG_SNAP_HI));
    wr_prescale  = wr_en && (wr_idx == REG_PRESCALE);
    start        = wr_control && wdata[CTRL_START];
    stop         = wr_control && wdata[CTRL_STOP];
    // ">=" keeps ticking sane if PRESCALE is lowered below the running count.
    tick         = run_reg && !force_reload_reg && (presc_cnt_reg >= prescale_reg);
    timeout      = tick && (count_reg == '0);

    count_next        = count_reg;
    period_next       = period_reg;
    snap_next         = snap_reg;
    presc_cnt_next    = presc_cnt_reg;
    prescale_next     = prescale_reg;
    run_next          = run_reg;
    to_next           = to_reg;
    ito_next          = ito_reg;
    cont_next         = cont_reg;
    force_reload_next = wr_period_lo || wr_period_hi;

    if (wr_period_lo)
      period_next = COUNTER_WIDTH'({period_wide[63:32], wdata});
    if (wr_period_hi)
      period_next = COUNTER_WIDTH'({wdata, period_wide[31:0]});
    if (wr_prescale)
      prescale_next = PRESCALE_WIDTH'(wdata);
    if (wr_snap)
      snap_next = count_reg;
    if (wr_control) begin
      ito_next  = wdata[CTRL_ITO];
      cont_next = wdata[CTRL_CONT];
    end

    if (force_reload_reg) begin
      count_next     = period_reg;
      presc_cnt_next = '0;
      run_next       = 1'b0;
    end else if (run_reg) begin
      if (tick) begin
        presc_cnt_next = '0;
        count_next     = timeout ? period_reg : count_reg - 1'b1;
      end else begin
        presc_cnt_next = presc_cnt_reg + 1'b1;
      end
    end

    if (timeout && !cont_reg)
      run_next = 1'b0;
    if (stop)
      run_next = 1'b0;
    if (start) begin
      run_next       = 1'b1;
      presc_cnt_next = '0;
    end

    // A timeout in the same cycle as a status write must not be lost.
    if (wr_status)
      to_next = 1'b0;
    if (timeout)
      to_next = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      REG_STATUS:    rd_data = status_word(run_reg, to_reg);
      REG_CONTROL:   rd_data = control_word(cont_reg, ito_reg);
      REG_PERIOD_LO: rd_data = period_wide[31:0];
      REG_PERIOD_HI: rd_data = period_wide[63:32];
      REG_SNAP_LO:   rd_data = snap_wide[31:0];
      REG_SNAP_HI:   rd_data = snap_wide[63:32];
      REG_PRESCALE:  rd_data = 32'(prescale_reg);
      default:       rd_data = '0;
    endcase
  end

  assign irq = to_reg && ito_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg        <= PERIOD_INIT;
      period_reg       <= PERIOD_INIT;
      snap_reg         <= '0;
      presc_cnt_reg    <= '0;
      prescale_reg     <= '0;
      run_reg          <= 1'b0;
      to_reg           <= 1'b0;
      ito_reg          <= 1'b0;
      cont_reg         <= 1'b0;
      force_reload_reg <= 1'b0;
    end else begin
      count_reg        <= count_next;
      period_reg       <= period_next;
      snap_reg         <= snap_next;
      presc_cnt_reg    <= presc_cnt_next;
      prescale_reg     <= prescale_next;
      run_reg          <= run_next;
      to_reg           <= to_next;
      ito_reg          <= ito_next;
      cont_reg         <= cont_next;
      force_reload_reg <= force_reload_next;
    end
  end

endmodule

// File: rtl/soc_multi_timer.sv
// Multi-channel Avalon-MM interval timer: address decode, registered read
// mux and interrupt combining around NUM_CHANNELS timer channels.
module soc_multi_timer
  import soc_timer_pkg::*;
#(
  parameter int          NUM_CHANNELS   = 4,
  parameter int          COUNTER_WIDTH  = 32,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [63:0] PERIOD_RESET   = 64'd49999
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [$clog2(NUM_CHANNELS)+2:0] address,
  input  logic                            chipselect,
  input  logic                            write_n,
  input  logic [31:0]                     writedata,
  output logic [31:0]                     readdata,
  output logic                            irq,
  output logic [NUM_CHANNELS-1:0]         irq_vec
);

  logic [4:0]  ch_sel;
  logic [2:0]  reg_sel;
  logic        wr_strobe;
  logic [31:0] ch_rd_data [NUM_CHANNELS];
  logic [31:0] rd_mux;
  logic [31:0] readdata_reg;

  // Channel field is empty when NUM_CHANNELS is 1; the shift handles that.
  assign ch_sel    = 5'(address >> 3);
  assign reg_sel   = address[2:0];
  assign wr_strobe = chipselect && !write_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      soc_timer_channel #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .PERIOD_RESET  (PERIOD_RESET)
      ) u_chan (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (wr_strobe && (ch_sel == 5'(gi))),
        .wr_idx (reg_sel),
        .wdata  (writedata),
        .rd_idx (reg_sel),
        .rd_data(ch_rd_data[gi]),
        .irq    (irq_vec[gi])
      );
    end
  endgenerate

  // Channels at or above NUM_CHANNELS fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_sel == 5'(i))
        rd_mux = ch_rd_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata_reg <= '0;
    else
      readdata_reg <= rd_mux;
  end

  assign readdata = readdata_reg;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_soc_multi_timer.sv
// Self-checking bench for soc_multi_timer: register-map vector table, directed
// timing sequences and randomized runs against an arithmetic timer model.
module tb_soc_multi_timer;

  localparam int NCH = 3;
  localparam int CW  = 48;
  localparam int PW  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [NCH-1:0] irq_vec;

  int unsigned cyc = 0;
  int unsigned last_wr_edge = 0;
  int unsigned last_rd_edge = 0;
  int n_checks = 0;
  int n_fail   = 0;

  soc_multi_timer #(
    .NUM_CHANNELS  (NCH),
    .COUNTER_WIDTH (CW),
    .PRESCALE_WIDTH(PW),
    .PERIOD_RESET  (64'd49999)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_vec   (irq_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // All bus tasks are entered and left on a falling edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address    = 5'(ch * 8 + r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect   = 1'b0;
    write_n      = 1'b1;
    last_wr_edge = cyc;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address    = 5'(ch * 8 + r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect   = 1'b0;
    d            = readdata;
    last_rd_edge = cyc;
  endtask

  task automatic wait_edge(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Counter value after j prescaled ticks from a fresh start at period n.
  function automatic longint unsigned model_count(input longint unsigned n, input int unsigned j,
                                                  input bit cont);
    if (cont) return n - (longint'(j) % (n + 1));
    if (longint'(j) >= n + 1) return n;
    return n - longint'(j);
  endfunction

  typedef struct {
    bit          wr;
    int          ch;
    int          r;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[29];

  initial begin
    logic [31:0] rv;
    logic [31:0] lo, hi;
    int unsigned s;

    vecs[0]  = '{0, 0, 2, 32'd49999};
    vecs[1]  = '{0, 0, 3, 32'h0};
    vecs[2]  = '{0, 0, 0, 32'h0};
    vecs[3]  = '{0, 0, 1, 32'h0};
    vecs[4]  = '{0, 0, 6, 32'h0};
    vecs[5]  = '{0, 0, 4, 32'h0};
    vecs[6]  = '{0, 2, 2, 32'd49999};
    vecs[7]  = '{0, 3, 2, 32'h0};
    vecs[8]  = '{1, 0, 6, 32'hFFFF_FFFF};
    vecs[9]  = '{0, 0, 6, 32'h0000_FFFF};
    vecs[10] = '{1, 0, 1, 32'h0000_000F};
    vecs[11] = '{0, 0, 1, 32'h3};
    vecs[12] = '{0, 0, 0, 32'h2};
    vecs[13] = '{1, 0, 3, 32'hFFFF_FFFF};
    vecs[14] = '{0, 0, 3, 32'h0000_FFFF};
    vecs[15] = '{0, 0, 0, 32'h0};
    vecs[16] = '{1, 0, 2, 32'h1234_5678};
    vecs[17] = '{0, 0, 2, 32'h1234_5678};
    vecs[18] = '{1, 0, 4, 32'h0};
    vecs[19] = '{0, 0, 4, 32'h1234_5678};
    vecs[20] = '{0, 0, 5, 32'h0000_FFFF};
    vecs[21] = '{1, 3, 2, 32'h0000_DEAD};
    vecs[22] = '{0, 3, 2, 32'h0};
    vecs[23] = '{1, 0, 7, 32'h0000_FFFF};
    vecs[24] = '{0, 0, 7, 32'h0};
    vecs[25] = '{1, 1, 1, 32'hFFFF_FFF0};
    vecs[26] = '{0, 1, 1, 32'h0};
    vecs[27] = '{1, 1, 0, 32'hFFFF_FFFF};
    vecs[28] = '{0, 1, 0, 32'h0};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    check("reset_irq", 64'(irq), 64'h0);
    check("reset_readdata", 64'(readdata), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map vectors
    for (int i = 0; i < 29; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].ch, vecs[i].r, vecs[i].val);
        $display("wr   ch%0d reg%0d <= 0x%0h", vecs[i].ch, vecs[i].r, vecs[i].val);
      end else begin
        rd(vecs[i].ch, vecs[i].r, rv);
        check($sformatf("vec%0d_ch%0d_reg%0d", i, vecs[i].ch, vecs[i].r), 64'(rv), 64'(vecs[i].val));
      end
    end

    // ch1 continuous, period 5 clocks; status clears and collisions
    wr(1, 6, 0); wr(1, 2, 4); wr(1, 3, 0); wr(1, 1, 32'h7);
    s = last_wr_edge;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ch1_irq_k%0d", k), 64'(irq_vec[1]), 64'(k == 5));
      check($sformatf("ch1_irqor_k%0d", k), 64'(irq), 64'(k == 5));
    end
    check("ch0_irq_quiet", 64'(irq_vec[0]), 64'h0);
    wr(1, 0, 0);
    check("ch1_clear", 64'(irq_vec[1]), 64'h0);
    wait_edge(s + 9);
    check("ch1_before_2nd", 64'(irq_vec[1]), 64'h0);
    wait_edge(s + 10);
    check("ch1_2nd_timeout", 64'(irq_vec[1]), 64'h1);
    wr(1, 0, 0);
    check("ch1_clear2", 64'(irq_vec[1]), 64'h0);
    wait_edge(s + 14);
    wr(1, 0, 0);
    check("ch1_clear_vs_timeout", 64'(irq_vec[1]), 64'h1);
    wr(1, 0, 0);
    check("ch1_clear3", 64'(irq_vec[1]), 64'h0);
    wait_edge(s + 19);
    wr(1, 1, 32'h9);
    check("ch1_stop_vs_timeout_irq", 64'(irq_vec[1]), 64'h1);
    wr(1, 4, 0);
    rd(1, 4, rv);
    check("ch1_stop_reloaded", 64'(rv), 64'd4);
    rd(1, 0, rv);
    check("ch1_stop_status", 64'(rv), 64'h1);
    rd(1, 1, rv);
    check("ch1_ctrl_pulses_zero", 64'(rv), 64'h1);

    // ch0 one-shot with prescale: timeout 12 clocks after START
    wr(0, 6, 3); wr(0, 2, 2); wr(0, 3, 0); wr(0, 1, 32'h5);
    s = last_wr_edge;
    wait_edge(s + 11);
    check("ch0_oneshot_pre", 64'(irq_vec[0]), 64'h0);
    wait_edge(s + 12);
    check("ch0_oneshot_timeout", 64'(irq_vec[0]), 64'h1);
    rd(0, 0, rv);
    check("ch0_oneshot_status", 64'(rv), 64'h1);
    wait_edge(s + 30);
    wr(0, 4, 0);
    rd(0, 4, rv);
    check("ch0_oneshot_hold", 64'(rv), 64'd2);

    // ch2 48-bit period across the word boundary
    wr(2, 6, 1); wr(2, 3, 1); wr(2, 2, 0); wr(2, 1, 32'h6);
    s = last_wr_edge;
    wait_edge(s + 40);
    wr(2, 4, 0);
    rd(2, 4, lo);
    rd(2, 5, hi);
    check("ch2_snap48", {16'h0, hi[15:0], lo}, 64'h1_0000_0000 - 64'd20);
    check("ch2_snap_hi_upper", 64'(hi[31:16]), 64'h0);
    rd(2, 3, rv);
    check("ch2_period_hi", 64'(rv), 64'h1);

    // Randomized runs against the arithmetic model
    for (int it = 0; it < 24; it++) begin
      int ch, p, n, idle;
      bit cont;
      int unsigned e_w, j;
      longint unsigned exp_cnt;
      ch   = int'($urandom_range(0, NCH - 1));
      p    = int'($urandom_range(0, 4));
      n    = int'($urandom_range(0, 12));
      cont = 1'($urandom_range(0, 1));
      idle = int'($urandom_range(0, 60));
      wr(ch, 6, 32'(p)); wr(ch, 2, 32'(n)); wr(ch, 3, 0); wr(ch, 0, 0);
      wr(ch, 1, 32'h5 | (32'(cont) << 1));
      s = last_wr_edge;
      repeat (idle) @(negedge clk);
      wr(ch, 4, 0);
      e_w = last_wr_edge;
      j = (e_w - s - 1) / unsigned'(p + 1);
      exp_cnt = model_count(longint'(n), j, cont);
      rd(ch, 4, lo);
      rd(ch, 5, hi);
      check($sformatf("rnd%0d_ch%0d_p%0d_n%0d_c%0d_snap", it, ch, p, n, cont),
            {hi, lo}, exp_cnt);
      rd(ch, 0, rv);
      j = (last_rd_edge - s - 1) / unsigned'(p + 1);
      check($sformatf("rnd%0d_status", it), 64'(rv),
            64'({(cont || j < unsigned'(n + 1)), (j >= unsigned'(n + 1))}));
      j = (last_rd_edge - s) / unsigned'(p + 1);
      check($sformatf("rnd%0d_irq", it), 64'(irq_vec[ch]), 64'(j >= unsigned'(n + 1)));
    end

    // Asynchronous reset while counting with irq high
    wr(1, 6, 0); wr(1, 2, 3); wr(1, 3, 0); wr(1, 1, 32'h7);
    s = last_wr_edge;
    wait_edge(s + 6);
    rd(1, 0, rv);
    check("pre_reset_status", 64'(rv), 64'h3);
    check("pre_reset_irq", 64'(irq), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", 64'(irq), 64'h0);
    check("async_reset_irq_vec", 64'(irq_vec), 64'h0);
    check("async_reset_readdata", 64'(readdata), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(1, 0, rv);
    check("post_reset_status", 64'(rv), 64'h0);
    wr(1, 4, 0);
    rd(1, 4, rv);
    check("post_reset_counter", 64'(rv), 64'd49999);
    rd(1, 2, rv);
    check("post_reset_period", 64'(rv), 64'd49999);
    rd(1, 6, rv);
    check("post_reset_prescale", 64'(rv), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
